// File: rtl/traffic_pkg.sv
// Shared phase codes, lamp encodings and start-mode codes for the intersection scheduler.
package traffic_pkg;

  localparam int unsigned PHASE_W = 3;
  localparam int unsigned LIGHT_W = 3;

  typedef enum logic [PHASE_W-1:0] {
    INIT      = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALL_RED_A = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    ALL_RED_B = 3'd6
  } phase_t;

  // Lamp heads are {red,yellow,green}
  localparam logic [LIGHT_W-1:0] L_RED = 3'b100;
  localparam logic [LIGHT_W-1:0] L_YEL = 3'b010;
  localparam logic [LIGHT_W-1:0] L_GRN = 3'b001;

  localparam logic [1:0] M_STOP = 2'b00;
  localparam logic [1:0] M_HOLD = 2'b01;
  localparam logic [1:0] M_GO   = 2'b10;
  localparam logic [1:0] M_SLOW = 2'b11;

  function automatic phase_t next_phase(input phase_t p);
    case (p)
      NS_GREEN:  return NS_YELLOW;
      NS_YELLOW: return ALL_RED_A;
      ALL_RED_A: return EW_GREEN;
      EW_GREEN:  return EW_YELLOW;
      EW_YELLOW: return ALL_RED_B;
      default:   return NS_GREEN;
    endcase
  endfunction

  // Returns {ns_light, ew_light}; anything not a green/yellow phase is red on both heads
  function automatic logic [2*LIGHT_W-1:0] lights_of(input phase_t p);
    case (p)
      NS_GREEN:  return {L_GRN, L_RED};
      NS_YELLOW: return {L_YEL, L_RED};
      EW_GREEN:  return {L_RED, L_GRN};
      EW_YELLOW: return {L_RED, L_YEL};
      default:   return {L_RED, L_RED};
    endcase
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// One-second time base: counts 0..TICK_DIV-1 while enabled and pulses tick on wrap.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PRE_W-1:0] cnt_q, cnt_d;
  logic             wrap_c;

  assign wrap_c = (cnt_q == PRE_W'(TICK_DIV - 1));
  assign tick   = en && wrap_c;

  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = wrap_c ? '0 : cnt_q + PRE_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Two-road intersection sequencer: phase FSM, countdown, pause toggle, pedestrian
// request latching with green cut, and registered lamp/walk outputs.
module intersection_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned GREEN_T  = 8,
  parameter int unsigned YELLOW_T = 3,
  parameter int unsigned ALLRED_T = 1,
  parameter int unsigned SHORT_T  = 3,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pause,
  input  logic [1:0]       start_mode,
  input  logic             ped_req_ns,
  input  logic             ped_req_ew,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic             walk_ns,
  output logic             walk_ew,
  output logic [CNT_W-1:0] countdown,
  output logic [2:0]       phase,
  output logic             paused
);

  phase_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             paused_q, paused_d;
  logic             req_ns_q, req_ns_d, req_ew_q, req_ew_d;
  logic             walk_ns_q, walk_ns_d, walk_ew_q, walk_ew_d;
  logic [2:0]       ns_light_q, ns_light_d, ew_light_q, ew_light_d;
  logic             pause_prev_q, ped_ns_prev_q, ped_ew_prev_q;
  logic             pause_edge_c, ns_edge_c, ew_edge_c, tick_c, pre_en_c;

  function automatic logic [CNT_W-1:0] dur(input phase_t p);
    case (p)
      NS_GREEN, EW_GREEN:   return CNT_W'(GREEN_T);
      NS_YELLOW, EW_YELLOW: return CNT_W'(YELLOW_T);
      default:              return CNT_W'(ALLRED_T);
    endcase
  endfunction

  assign pause_edge_c = pause & ~pause_prev_q;
  assign ns_edge_c    = ped_req_ns & ~ped_ns_prev_q;
  assign ew_edge_c    = ped_req_ew & ~ped_ew_prev_q;
  assign pre_en_c     = !paused_q && (state_q != INIT);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (pre_en_c),
    .tick (tick_c)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    paused_d  = paused_q ^ pause_edge_c;
    req_ns_d  = req_ns_q | ns_edge_c;
    req_ew_d  = req_ew_q | ew_edge_c;
    walk_ns_d = walk_ns_q;
    walk_ew_d = walk_ew_q;

    if (state_q == INIT) begin
      case (start_mode)
        M_STOP: begin state_d = ALL_RED_B; cnt_d = CNT_W'(ALLRED_T); paused_d = 1'b0; end
        M_HOLD: begin state_d = ALL_RED_B; cnt_d = CNT_W'(ALLRED_T); paused_d = 1'b1; end
        M_GO:   begin state_d = NS_GREEN;  cnt_d = CNT_W'(GREEN_T);  end
        default: begin state_d = NS_YELLOW; cnt_d = CNT_W'(YELLOW_T); end
      endcase
    end else begin
      if (!paused_q && tick_c) begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = next_phase(state_q);
          cnt_d   = dur(state_d);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      // Cross-street request shortens a long green; honoured even while paused
      if (((state_q == NS_GREEN && ew_edge_c) || (state_q == EW_GREEN && ns_edge_c)) &&
          cnt_q > CNT_W'(SHORT_T))
        cnt_d = CNT_W'(SHORT_T);
    end

    if (state_d != NS_GREEN) walk_ns_d = 1'b0;
    else if (state_q != NS_GREEN) begin
      walk_ns_d = req_ns_q | ns_edge_c;
      req_ns_d  = 1'b0;
    end
    if (state_d != EW_GREEN) walk_ew_d = 1'b0;
    else if (state_q != EW_GREEN) begin
      walk_ew_d = req_ew_q | ew_edge_c;
      req_ew_d  = 1'b0;
    end

    {ns_light_d, ew_light_d} = lights_of(state_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= INIT;
      cnt_q         <= '0;
      paused_q      <= 1'b0;
      req_ns_q      <= 1'b0;
      req_ew_q      <= 1'b0;
      walk_ns_q     <= 1'b0;
      walk_ew_q     <= 1'b0;
      ns_light_q    <= L_RED;
      ew_light_q    <= L_RED;
      pause_prev_q  <= 1'b0;
      ped_ns_prev_q <= 1'b0;
      ped_ew_prev_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      paused_q      <= paused_d;
      req_ns_q      <= req_ns_d;
      req_ew_q      <= req_ew_d;
      walk_ns_q     <= walk_ns_d;
      walk_ew_q     <= walk_ew_d;
      ns_light_q    <= ns_light_d;
      ew_light_q    <= ew_light_d;
      pause_prev_q  <= pause;
      ped_ns_prev_q <= ped_req_ns;
      ped_ew_prev_q <= ped_req_ew;
    end
  end

  assign phase     = state_q;
  assign countdown = cnt_q;
  assign paused    = paused_q;
  assign walk_ns   = walk_ns_q;
  assign walk_ew   = walk_ew_q;
  assign ns_light  = ns_light_q;
  assign ew_light  = ew_light_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Scoreboard bench for intersection_phase_scheduler with a fast (2-cycle) tick.
module tb_intersection_phase_scheduler;

  localparam int unsigned CNT_W = 8;
  localparam int RED = 4, YEL = 2, GRN = 1;
  localparam int O_PH = 0, O_CD = 1, O_NS = 2, O_EW = 3, O_WN = 4, O_WE = 5, O_PA = 6;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             pause = 1'b0;
  logic [1:0]       start_mode = 2'b00;
  logic             ped_req_ns = 1'b0;
  logic             ped_req_ew = 1'b0;
  logic [2:0]       ns_light, ew_light, phase;
  logic             walk_ns, walk_ew, paused;
  logic [CNT_W-1:0] countdown;

  always #5 clk = ~clk;

  intersection_phase_scheduler #(
    .TICK_DIV(2), .GREEN_T(8), .YELLOW_T(3), .ALLRED_T(1), .SHORT_T(3), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .pause(pause), .start_mode(start_mode),
    .ped_req_ns(ped_req_ns), .ped_req_ew(ped_req_ew),
    .ns_light(ns_light), .ew_light(ew_light), .walk_ns(walk_ns), .walk_ew(walk_ew),
    .countdown(countdown), .phase(phase), .paused(paused)
  );

  int errs = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      O_PH:    return 32'(phase);
      O_CD:    return 32'(countdown);
      O_NS:    return 32'(ns_light);
      O_EW:    return 32'(ew_light);
      O_WN:    return 32'(walk_ns);
      O_WE:    return 32'(walk_ew);
      default: return 32'(paused);
    endcase
  endfunction

  task automatic expect_out(input string tag, input int sel, input int val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = 32'(val);
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [1:0] mode);
    reset      = 1'b0;
    start_mode = mode;
    pause      = 1'b0;
    ped_req_ns = 1'b0;
    ped_req_ew = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  task automatic wait_phase(input string tag, input int p, input int budget);
    int n = 0;
    while (32'(phase) != 32'(p) && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, 32'(phase), 32'(p));
  endtask

  // Safety monitor: heads never both non-red, countdown never zero once running
  always @(negedge clk) begin
    if (reset && phase != 3'd0) begin
      chk("safe_heads", 32'((ns_light != 3'b100) && (ew_light != 3'b100)), 32'd0);
      chk("cd_nonzero", 32'(countdown != '0), 32'd1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    step(2);
    expect_out("rst_phase", O_PH, 0);  expect_out("rst_ns", O_NS, RED);
    expect_out("rst_ew", O_EW, RED);   expect_out("rst_cd", O_CD, 0);
    expect_out("rst_wn", O_WN, 0);     expect_out("rst_we", O_WE, 0);
    expect_out("rst_pa", O_PA, 0);
    drain();

    // Go mode timing through the ring
    do_reset(2'b10);
    expect_out("go_phase", O_PH, 1); expect_out("go_ns", O_NS, GRN);
    expect_out("go_ew", O_EW, RED);  expect_out("go_cd", O_CD, 8);
    step(1); drain();
    expect_out("go_y_phase", O_PH, 2); expect_out("go_y_cd", O_CD, 3);
    expect_out("go_y_ns", O_NS, YEL);
    step(16); drain();
    expect_out("go_ar_phase", O_PH, 3); expect_out("go_ar_ns", O_NS, RED);
    expect_out("go_ar_ew", O_EW, RED);  expect_out("go_ar_cd", O_CD, 1);
    step(6); drain();
    wait_phase("go_to_ewg", 4, 10);
    expect_out("go_ewg_ew", O_EW, GRN); expect_out("go_ewg_walk", O_WE, 0);
    drain();

    // Stop mode
    do_reset(2'b00);
    expect_out("stop_phase", O_PH, 6); expect_out("stop_cd", O_CD, 1);
    expect_out("stop_pa", O_PA, 0);
    step(1); drain();
    expect_out("stop_next", O_PH, 1); expect_out("stop_next_cd", O_CD, 8);
    step(2); drain();

    // Hold mode: frozen until a pause pulse
    do_reset(2'b01);
    expect_out("hold_phase", O_PH, 6); expect_out("hold_pa", O_PA, 1);
    step(1); drain();
    expect_out("hold_stay", O_PH, 6); expect_out("hold_stay_cd", O_CD, 1);
    step(20); drain();
    pause = 1'b1;
    expect_out("hold_unpause", O_PA, 0);
    step(1); drain();
    pause = 1'b0;
    expect_out("hold_resume", O_PH, 1); expect_out("hold_resume_cd", O_CD, 8);
    step(2); drain();

    // Pause in NS_GREEN at countdown 5, prescaler phase preserved across resume
    expect_out("pz_cd5", O_CD, 5);
    step(6); drain();
    pause = 1'b1;
    expect_out("pz_on", O_PA, 1); expect_out("pz_on_cd", O_CD, 5);
    step(1); drain();
    step(1);
    pause = 1'b0;
    expect_out("pz_hold_cd", O_CD, 5); expect_out("pz_hold_ph", O_PH, 1);
    step(20); drain();
    pause = 1'b1;
    expect_out("pz_off", O_PA, 0); expect_out("pz_off_cd", O_CD, 5);
    step(1); drain();
    pause = 1'b0;
    expect_out("pz_resume_cd", O_CD, 4);
    step(1); drain();
    expect_out("pz_resume_cd2", O_CD, 3);
    step(2); drain();

    // Green cut by EW request, then walk_ew during EW_GREEN
    do_reset(2'b10);
    expect_out("cut_pre_cd", O_CD, 7);
    step(3); drain();
    ped_req_ew = 1'b1;
    expect_out("cut_cd", O_CD, 3); expect_out("cut_ph", O_PH, 1);
    step(1); drain();
    ped_req_ew = 1'b0;
    wait_phase("cut_to_ewg", 4, 60);
    expect_out("walk_ew_entry", O_WE, 1); expect_out("walk_ns_off", O_WN, 0);
    drain();
    for (int i = 0; i < 40 && phase == 3'd4; i++) begin
      expect_out("walk_ew_hold", O_WE, 1);
      drain();
      step(1);
    end
    expect_out("ewy_phase", O_PH, 5); expect_out("walk_ew_drop", O_WE, 0);
    drain();
    wait_phase("cut_to_ewg2", 4, 120);
    expect_out("walk_ew_served", O_WE, 0); expect_out("ewg2_cd", O_CD, 8);
    drain();
    ped_req_ns = 1'b1;
    expect_out("cut_ew_cd", O_CD, 3); expect_out("cut_ew_ph", O_PH, 4);
    step(1); drain();
    ped_req_ns = 1'b0;
    wait_phase("cut_to_nsg", 1, 60);
    expect_out("walk_ns_entry", O_WN, 1); expect_out("nsg_cd", O_CD, 8);
    drain();

    // Asynchronous reset during EW_YELLOW, then slow-mode restart
    wait_phase("to_ewy", 5, 120);
    step(1);
    reset = 1'b0;
    #1;
    expect_out("arst_phase", O_PH, 0); expect_out("arst_ns", O_NS, RED);
    expect_out("arst_ew", O_EW, RED);  expect_out("arst_cd", O_CD, 0);
    expect_out("arst_wn", O_WN, 0);    expect_out("arst_we", O_WE, 0);
    expect_out("arst_pa", O_PA, 0);
    drain();
    start_mode = 2'b11;
    step(1);
    reset = 1'b1;
    expect_out("slow_phase", O_PH, 2); expect_out("slow_cd", O_CD, 3);
    expect_out("slow_ns", O_NS, YEL);  expect_out("slow_ew", O_EW, RED);
    step(1); drain();
    step(4);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
